// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a common-anode seven-segment display with a per-digit anode guard interval.
// Optional leading-zero blanking is compiled in when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned GUARD   = 4,
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam int unsigned GRD_W = $clog2(GUARD + 1);
    localparam int unsigned VAL_W = 4 * DIGITS;

    // Active-low ABCDEFG pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Registered state
    logic [PRE_W-1:0]  pre_q,   pre_nxt;
    logic [GRD_W-1:0]  grd_q,   grd_nxt;
    logic              run_q,   run_nxt;
    logic              pflag_q, pflag_nxt;
    logic [VAL_W-1:0]  pval_q,  pval_nxt;
    logic [DIGITS-1:0] pdp_q,   pdp_nxt;
    logic [DIGITS-1:0] pblk_q,  pblk_nxt;
    logic [VAL_W-1:0]  sval_q,  sval_nxt;
    logic [DIGITS-1:0] sdp_q,   sdp_nxt;
    logic [DIGITS-1:0] sblk_q,  sblk_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [DIGITS-1:0] an_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic              ft_nxt;

    // Combinational helpers
    logic              tick;
    logic              wrap;
    logic [DIGITS-1:0] lzb;
    logic [DIGITS-1:0] an_sel;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;

`ifdef SEVEN_SEG_LZB_EN
    logic              lzb_seen;

    // Dark every digit above the most significant nonzero shadow nibble; digit 0 always shows.
    always_comb begin
        lzb      = '0;
        lzb_seen = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            if (sval_q[4*k +: 4] != 4'h0) begin
                lzb_seen = 1'b1;
            end
            if (!lzb_seen) begin
                lzb[k] = 1'b1;
            end
        end
    end
`else
    assign lzb = '0;
`endif

    // Shadow entry and anode pattern for the digit currently selected.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        an_sel    = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_nib   = sval_q[4*k +: 4];
                cur_dp    = sdp_q[k];
                cur_blank = sblk_q[k] | lzb[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        pre_nxt   = pre_q;
        grd_nxt   = grd_q;
        run_nxt   = run_q;
        pflag_nxt = pflag_q;
        pval_nxt  = pval_q;
        pdp_nxt   = pdp_q;
        pblk_nxt  = pblk_q;
        sval_nxt  = sval_q;
        sdp_nxt   = sdp_q;
        sblk_nxt  = sblk_q;
        seg_nxt   = 7'h7F;
        dp_nxt    = 1'b1;
        an_nxt    = an;
        idx_nxt   = digit_idx;
        ft_nxt    = 1'b0;

        tick = enable && (pre_q == PRE_W'(CLK_DIV - 1));
        wrap = tick && (digit_idx == IDX_W'(DIGITS - 1));

        if (!enable) begin
            pre_nxt = '0;
            grd_nxt = '0;
            idx_nxt = '0;
            run_nxt = 1'b0;
            an_nxt  = '1;
        end else begin
            run_nxt = 1'b1;
            pre_nxt = tick ? '0 : pre_q + PRE_W'(1);
            seg_nxt = cur_blank ? 7'h7F : hex7(cur_nib);
            dp_nxt  = cur_blank | ~cur_dp;
            ft_nxt  = wrap;
            if (tick) begin
                idx_nxt = wrap ? '0 : digit_idx + IDX_W'(1);
                grd_nxt = GRD_W'(GUARD);
                an_nxt  = '1;
            end else if (!run_q) begin
                // First enabled cycle opens a full slot for digit 0.
                grd_nxt = GRD_W'(GUARD);
                an_nxt  = '1;
            end else if (grd_q != '0) begin
                grd_nxt = grd_q - GRD_W'(1);
                if (grd_q == GRD_W'(1)) begin
                    an_nxt = an_sel;
                end
            end
        end

        // Whole-word transfer only at the frame boundary to avoid tearing.
        if (wrap && pflag_q) begin
            sval_nxt  = pval_q;
            sdp_nxt   = pdp_q;
            sblk_nxt  = pblk_q;
            pflag_nxt = 1'b0;
        end
        if (load) begin
            pval_nxt  = value;
            pdp_nxt   = dp_in;
            pblk_nxt  = blank_in;
            pflag_nxt = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            grd_q      <= '0;
            run_q      <= 1'b0;
            pflag_q    <= 1'b0;
            pval_q     <= '0;
            pdp_q      <= '0;
            pblk_q     <= '1;
            sval_q     <= '0;
            sdp_q      <= '0;
            sblk_q     <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= '1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            pre_q      <= pre_nxt;
            grd_q      <= grd_nxt;
            run_q      <= run_nxt;
            pflag_q    <= pflag_nxt;
            pval_q     <= pval_nxt;
            pdp_q      <= pdp_nxt;
            pblk_q     <= pblk_nxt;
            sval_q     <= sval_nxt;
            sdp_q      <= sdp_nxt;
            sblk_q     <= sblk_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            digit_idx  <= idx_nxt;
            frame_tick <= ft_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (DIGITS=4, CLK_DIV=8, GUARD=2); edge numbers count posedges after reset release.
module tb_seven_seg_scan;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned GUARD   = 2;

`ifdef SEVEN_SEG_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    seven_seg_scan #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_idx", 32'(digit_idx), 32'h0);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        // Blank shadow: anodes scan, segments stay dark.
        step(1);  // e1
        chk("e1_an", 32'(an), 32'hF);
        chk("e1_seg", 32'(seg), 32'h7F);
        step(2);  // e3
        chk("e3_an", 32'(an), 32'hE);
        chk("e3_seg", 32'(seg), 32'h7F);
        step(5);  // e8
        chk("e8_idx", 32'(digit_idx), 32'h1);
        chk("e8_an", 32'(an), 32'hF);
        step(2);  // e10
        chk("e10_an", 32'(an), 32'hD);
        step(22); // e32
        chk("e32_idx", 32'(digit_idx), 32'h0);
        chk("e32_ft", 32'(frame_tick), 32'h1);
        step(1);  // e33
        chk("e33_ft", 32'(frame_tick), 32'h0);
        step(31); // e64
        chk("e64_ft", 32'(frame_tick), 32'h1);

        // Word 12A5 with DP on digit 2.
        load  = 1'b1;
        value = 16'h12A5;
        dp_in = 4'b0100;
        step(1);  // e65
        load = 1'b0;
        step(31); // e96
        chk("e96_an", 32'(an), 32'hF);
        chk("e96_seg_old", 32'(seg), 32'h7F);
        chk("e96_ft", 32'(frame_tick), 32'h1);
        step(1);  // e97
        chk("d0_seg", 32'(seg), 32'h24);
        chk("d0_dp", 32'(dp), 32'h1);
        chk("e97_an", 32'(an), 32'hF);
        step(1);  // e98
        chk("d0_an", 32'(an), 32'hE);
        step(6);  // e104
        chk("e104_an", 32'(an), 32'hF);
        chk("e104_seg_hold", 32'(seg), 32'h24);
        step(1);  // e105
        chk("d1_seg", 32'(seg), 32'h08);
        chk("e105_an", 32'(an), 32'hF);
        step(1);  // e106
        chk("d1_an", 32'(an), 32'hD);
        step(7);  // e113
        chk("d2_seg", 32'(seg), 32'h12);
        chk("d2_dp", 32'(dp), 32'h0);
        step(1);  // e114
        chk("d2_an", 32'(an), 32'hB);
        step(7);  // e121
        chk("d3_seg", 32'(seg), 32'h4F);
        chk("d3_dp", 32'(dp), 32'h1);
        step(1);  // e122
        chk("d3_an", 32'(an), 32'h7);
        step(6);  // e128

        // Back-to-back loads: last one wins, no tearing mid-frame.
        load  = 1'b1;
        value = 16'h1111;
        dp_in = 4'h0;
        step(1);  // e129
        value = 16'h2222;
        step(1);  // e130
        load = 1'b0;
        step(7);  // e137
        chk("notear_seg", 32'(seg), 32'h08);
        step(24); // e161
        chk("last_wins_seg", 32'(seg), 32'h12);

        // Load landing on the wrap tick is shown one frame later.
        step(8);  // e169
        load  = 1'b1;
        value = 16'h4444;
        step(1);  // e170
        load = 1'b0;
        step(21); // e191
        load  = 1'b1;
        value = 16'h3333;
        step(1);  // e192
        load = 1'b0;
        chk("e192_ft", 32'(frame_tick), 32'h1);
        step(1);  // e193
        chk("wrapload_old", 32'(seg), 32'h4C);
        step(32); // e225
        chk("wrapload_new", 32'(seg), 32'h06);

        // Disable mid-slot on digit 2, then re-enable.
        step(20); // e245
        chk("pre_dis_an", 32'(an), 32'hB);
        chk("pre_dis_idx", 32'(digit_idx), 32'h2);
        enable = 1'b0;
        step(1);  // e246
        chk("dis_an", 32'(an), 32'hF);
        chk("dis_seg", 32'(seg), 32'h7F);
        chk("dis_dp", 32'(dp), 32'h1);
        chk("dis_idx", 32'(digit_idx), 32'h0);
        step(3);  // e249
        chk("dis_hold_an", 32'(an), 32'hF);
        enable = 1'b1;
        step(1);  // e250
        chk("ren_an", 32'(an), 32'hF);
        chk("ren_seg", 32'(seg), 32'h06);
        step(1);  // e251
        chk("ren_guard_an", 32'(an), 32'hF);
        step(1);  // e252
        chk("ren_d0_an", 32'(an), 32'hE);
        chk("ren_d0_idx", 32'(digit_idx), 32'h0);
        step(5);  // e257
        chk("ren_slot_idx", 32'(digit_idx), 32'h1);
        chk("ren_slot_an", 32'(an), 32'hF);

        // blank_in on digit 1: dark segments and DP, anode still scans.
        load     = 1'b1;
        value    = 16'h00F8;
        dp_in    = 4'b0011;
        blank_in = 4'b0010;
        step(1);  // e258
        load = 1'b0;
        step(24); // e282
        chk("bl_d0_seg", 32'(seg), 32'h00);
        chk("bl_d0_dp", 32'(dp), 32'h0);
        step(8);  // e290
        chk("bl_d1_idx", 32'(digit_idx), 32'h1);
        chk("bl_d1_seg", 32'(seg), 32'h7F);
        chk("bl_d1_dp", 32'(dp), 32'h1);
        step(1);  // e291
        chk("bl_d1_an", 32'(an), 32'hD);
        step(7);  // e298
        chk("bl_d2_seg", 32'(seg), LZB ? 32'h7F : 32'h01);

        // Leading-zero case 0030.
        load     = 1'b1;
        value    = 16'h0030;
        dp_in    = 4'b1000;
        blank_in = 4'b0000;
        step(1);  // e299
        load = 1'b0;
        step(15); // e314
        chk("lz_d0_seg", 32'(seg), 32'h01);
        step(8);  // e322
        chk("lz_d1_seg", 32'(seg), 32'h06);
        step(8);  // e330
        chk("lz_d2_seg", 32'(seg), LZB ? 32'h7F : 32'h01);
        step(8);  // e338
        chk("lz_d3_seg", 32'(seg), LZB ? 32'h7F : 32'h01);
        chk("lz_d3_dp", 32'(dp), LZB ? 32'h1 : 32'h0);

        // All-zero word.
        load  = 1'b1;
        value = 16'h0000;
        dp_in = 4'b0000;
        step(1);  // e339
        load = 1'b0;
        step(7);  // e346
        chk("z_d0_seg", 32'(seg), 32'h01);
        step(8);  // e354
        chk("z_d1_seg", 32'(seg), LZB ? 32'h7F : 32'h01);
        step(2);  // e356
        chk("z_d1_an", 32'(an), 32'hD);

        // Asynchronous reset mid-scan.
        rst_n = 1'b0;
        #1;
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_idx", 32'(digit_idx), 32'h0);
        chk("mrst_ft", 32'(frame_tick), 32'h0);
        step(2);
        chk("mrst_hold_an", 32'(an), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
